fetch_prefetch_queue: RTL and testbench

// - Parametrised instruction-fetch front end that replaces the single-entry fetch stage.
// - Issues sequential reads to instruction memory, which has a fixed read latency.
// - Buffers up to DEPTH fetched instructions in a first-word-fall-through queue and presents them to decode.
// - Handles decode back-pressure, and branch redirect with flush of the queue and of in-flight reads.
// - Sits between instruction memory and the decode stage inside the cpu top level.

---
 rtl/fetch_prefetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: sequential reads to a fixed-latency instruction memory,
// buffered in a first-word-fall-through queue with decode back-pressure and branch flush.
module fetch_prefetch_queue #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 4,
  parameter int                READ_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              im_read_enable,
  output logic [ADDR_W-1:0] im_read_address,
  input  logic [DATA_W-1:0] im_read_data,
  input  logic              id_stall_c,
  input  logic              branch_c,
  input  logic [ADDR_W-1:0] branch_pc,
  output logic              IF_ID_valid,
  output logic [DATA_W-1:0] IF_ID_IR,
  output logic [ADDR_W-1:0] IF_ID_nextPC
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0]       fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [READ_LATENCY-1:0] vld_sr_q;
  logic [ADDR_W-1:0]       addr_sr_q [READ_LATENCY];
  logic [DATA_W-1:0]       ir_mem_q  [DEPTH];
  logic [ADDR_W-1:0]       npc_mem_q [DEPTH];

  logic [CNT_W-1:0] inflight;
  logic             issue;
  logic             push;
  logic             pop;
  logic             head_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_sr_q[i]);
    end
  end

  // Credits count everything already buffered or still on its way back from memory.
  assign issue = reset_n && !branch_c &&
                 (({1'b0, count_q} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH));

  assign push       = vld_sr_q[READ_LATENCY-1];
  assign head_valid = (count_q != '0);
  assign pop        = head_valid && !id_stall_c;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (branch_c) begin
      fetch_pc_d = branch_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (push)  tail_d     = ptr_inc(tail_q);
      if (pop)   head_d     = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // One stage per cycle of memory latency; a flush kills every outstanding response.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_sr
    if (gi == 0) begin : g_first
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      vld_sr_q[gi] <= 1'b0;
        else if (branch_c) vld_sr_q[gi] <= 1'b0;
        else               vld_sr_q[gi] <= issue;
      end
      always_ff @(posedge clock) begin
        addr_sr_q[gi] <= fetch_pc_q;
      end
    end else begin : g_rest
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      vld_sr_q[gi] <= 1'b0;
        else if (branch_c) vld_sr_q[gi] <= 1'b0;
        else               vld_sr_q[gi] <= vld_sr_q[gi-1];
      end
      always_ff @(posedge clock) begin
        addr_sr_q[gi] <= addr_sr_q[gi-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !branch_c) begin
      ir_mem_q[tail_q]  <= im_read_data;
      npc_mem_q[tail_q] <= addr_sr_q[READ_LATENCY-1] + ADDR_W'(4);
    end
  end

  assign im_read_enable  = issue;
  assign im_read_address = fetch_pc_q;
  assign IF_ID_valid     = head_valid;
  assign IF_ID_IR        = head_valid ? ir_mem_q[head_q]  : '0;
  assign IF_ID_nextPC    = head_valid ? npc_mem_q[head_q] : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: three latency/depth configurations share one stimulus
// stream; each has its own memory model and a scoreboard filled at request time.
module tb_fetch_prefetch_queue;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_stall_c;
  logic        branch_c;
  logic [31:0] branch_pc;

  logic        en_w    [N];
  logic [31:0] addr_w  [N];
  logic [31:0] data_w  [N];
  logic        valid_w [N];
  logic [31:0] ir_w    [N];
  logic [31:0] npc_w   [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
    int          t;
  } exp_t;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < N; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;
    localparam int DEP = (gi == 2) ? 3 : 4;

    logic [3:0]  pv = '0;
    logic [31:0] pa [4];
    logic [31:0] exp_addr;
    exp_t        sb [$];

    fetch_prefetch_queue #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(DEP), .READ_LATENCY(LAT), .RESET_PC(32'h0)
    ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .im_read_enable (en_w[gi]),
      .im_read_address(addr_w[gi]),
      .im_read_data   (data_w[gi]),
      .id_stall_c     (id_stall_c),
      .branch_c       (branch_c),
      .branch_pc      (branch_pc),
      .IF_ID_valid    (valid_w[gi]),
      .IF_ID_IR       (ir_w[gi]),
      .IF_ID_nextPC   (npc_w[gi])
    );

    // Memory: answers every request LAT cycles later, garbage otherwise; it does not
    // know about branches, so stale responses really do come back.
    always @(posedge clock) begin
      pv    <= {pv[2:0], en_w[gi]};
      pa[0] <= addr_w[gi];
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
    assign data_w[gi] = pv[LAT-1] ? mem_word(pa[LAT-1]) : (32'hBAD0_0000 | 32'(cyc));

    function automatic logic head_ready();
      return (sb.size() > 0) && (sb[0].t + LAT + 1 <= cyc);
    endfunction

    always @(negedge clock) begin
      if (!reset_n) begin
        sb.delete();
        exp_addr <= 32'h0;
      end else begin
        check($sformatf("i%0d valid", gi), 32'(valid_w[gi]), 32'(head_ready()));
        if (head_ready()) begin
          check($sformatf("i%0d ir", gi), ir_w[gi], sb[0].ir);
          check($sformatf("i%0d npc", gi), npc_w[gi], sb[0].npc);
        end else begin
          check($sformatf("i%0d ir_nop", gi), ir_w[gi], 32'h0);
        end
        check($sformatf("i%0d issue", gi), 32'(en_w[gi]),
              32'(!branch_c && (sb.size() < DEP)));
        if (en_w[gi]) check($sformatf("i%0d addr", gi), addr_w[gi], exp_addr);
        if (branch_c) begin
          sb.delete();
          exp_addr <= branch_pc;
        end else begin
          if (head_ready() && !id_stall_c) begin
            $display("i%0d pop ir=%h npc=%h cycle=%0d", gi, sb[0].ir, sb[0].npc, cyc);
            void'(sb.pop_front());
          end
          if (en_w[gi]) begin
            sb.push_back('{mem_word(exp_addr), exp_addr + 32'd4, cyc});
            exp_addr <= exp_addr + 32'd4;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    id_stall_c = 1'b0;
    branch_c   = 1'b0;
    branch_pc  = 32'h0;
    step(2);
    for (int i = 0; i < N; i++) begin
      check($sformatf("i%0d rst_en", i), 32'(en_w[i]), 32'h0);
      check($sformatf("i%0d rst_valid", i), 32'(valid_w[i]), 32'h0);
      check($sformatf("i%0d rst_ir", i), ir_w[i], 32'h0);
      check($sformatf("i%0d rst_npc", i), npc_w[i], 32'h0);
    end
    reset_n = 1'b1;

    // Free-running sequential fetch.
    step(20);

    // Long decode stall: credits run out and issue stops.
    id_stall_c = 1'b1;
    step(10);
    @(negedge clock);
    for (int i = 0; i < N; i++) check($sformatf("i%0d stall_full", i), 32'(en_w[i]), 32'h0);
    step(1);
    id_stall_c = 1'b0;
    step(12);

    // Back-to-back branches, then a branch with reads in flight.
    branch_c  = 1'b1;
    branch_pc = 32'h80;
    step(1);
    branch_pc = 32'h40;
    step(1);
    branch_c = 1'b0;
    step(3);
    branch_c  = 1'b1;
    branch_pc = 32'h100;
    step(1);
    branch_c = 1'b0;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      check($sformatf("i%0d br_valid", i), 32'(valid_w[i]), 32'h0);
      check($sformatf("i%0d br_issue", i), 32'(en_w[i]), 32'h1);
      check($sformatf("i%0d br_addr", i), addr_w[i], 32'h100);
    end
    step(10);

    // Branch in a cycle where the head is being consumed.
    branch_c  = 1'b1;
    branch_pc = 32'h200;
    @(negedge clock);
    check("i0 pop_br_valid", 32'(valid_w[0]), 32'h1);
    step(1);
    branch_c = 1'b0;
    @(negedge clock);
    for (int i = 0; i < N; i++) check($sformatf("i%0d flush_cnt", i), 32'(valid_w[i]), 32'h0);
    step(10);

    // Asynchronous reset while the queue is full.
    id_stall_c = 1'b1;
    step(10);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("i%0d arst_en", i), 32'(en_w[i]), 32'h0);
      check($sformatf("i%0d arst_valid", i), 32'(valid_w[i]), 32'h0);
      check($sformatf("i%0d arst_ir", i), ir_w[i], 32'h0);
      check($sformatf("i%0d arst_npc", i), npc_w[i], 32'h0);
    end
    step(2);
    reset_n    = 1'b1;
    id_stall_c = 1'b0;
    @(negedge clock);
    for (int i = 0; i < N; i++) check($sformatf("i%0d restart_addr", i), addr_w[i], 32'h0);
    step(10);

    // Address wrap at the top of the address space.
    branch_c  = 1'b1;
    branch_pc = 32'hFFFF_FFE0;
    step(1);
    branch_c = 1'b0;
    step(100);

    // Irregular decode stalls.
    repeat (80) begin
      id_stall_c = ($urandom_range(0, 3) == 0);
      step(1);
    end
    id_stall_c = 1'b0;
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
